// File: rtl/booth_seq_accumulator.sv
// Sequential radix-4 Booth multiplier: accumulates one Booth row per clock
// into a 32-bit signed product, with valid/ready on both sides.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | accumulating one radix-4 digit per clock (8 digits)
// DONE  | product valid, held until the consumer asserts out_ready
module booth_seq_accumulator #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NDIG  = WIDTH / 2;
    localparam int CNT_W = $clog2(NDIG);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH:0]     b_ext;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      product_q;

    logic [2:0]         triple;
    logic [CNT_W:0]     shamt;
    logic [WIDTH:0]     pos_row;
    logic [WIDTH:0]     row;
    logic               neg;
    logic [PW-1:0]      addend;
    logic [PW-1:0]      acc_nx;
    logic               accept;
    logic               last_digit;

    assign shamt      = {cnt, 1'b0};
    assign triple     = b_ext[shamt +: 3];
    assign accept     = (state == S_IDLE) && in_valid;
    assign last_digit = (cnt == CNT_W'(NDIG - 1));

    // Row uses the generator's encoding: negative digits invert the row and
    // supply the +1 separately as comp, weighted at the digit position.
    always_comb begin
        pos_row = '0;
        neg     = 1'b0;
        case (triple)
            3'b001, 3'b010: pos_row = {a_q[WIDTH-1], a_q};
            3'b011:         pos_row = {a_q, 1'b0};
            3'b100: begin
                pos_row = {a_q, 1'b0};
                neg     = 1'b1;
            end
            3'b101, 3'b110: begin
                pos_row = {a_q[WIDTH-1], a_q};
                neg     = 1'b1;
            end
            default: begin
                pos_row = '0;
                neg     = 1'b0;
            end
        endcase
        row    = neg ? ~pos_row : pos_row;
        addend = ({{(PW-WIDTH-1){row[WIDTH]}}, row} + PW'(neg)) << shamt;
        acc_nx = acc + addend;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = S_RUN;
            S_RUN:   if (last_digit) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == S_IDLE);
        busy      = (state == S_RUN) || (state == S_DONE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_ext     <= '0;
            cnt       <= '0;
            acc       <= '0;
            product_q <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_ext <= {b, 1'b0};
            cnt   <= '0;
            acc   <= '0;
        end else if (state == S_RUN) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (last_digit) begin
                product_q <= acc_nx;
            end
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_accumulator.sv
// Directed bench for booth_seq_accumulator: hand-computed products, latency,
// backpressure, mid-operation reset, plus a short randomized run.
module tb_booth_seq_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    booth_seq_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, check latency and product, stall, then drain.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp, input int stall);
        int n;
        logic [31:0] held;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_product"}, product, exp);
        held = product;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_hold"}, product, held);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic signed [31:0] ref_p;
        int seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state, in_ready held low while rst_n is low.
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Directed products.
        run_op("3x5",        16'd3,      16'd5,      32'h0000_000F, 0);
        run_op("min_sq",     16'h8000,   16'h8000,   32'h4000_0000, 1);
        run_op("m1x7fff",    16'hFFFF,   16'h7FFF,   32'hFFFF_8001, 0);
        run_op("1xaaaa",     16'd1,      16'hAAAA,   32'hFFFF_AAAA, 0);
        run_op("x_zero",     16'h1234,   16'h0000,   32'h0000_0000, 0);
        run_op("max_sq",     16'h7FFF,   16'h7FFF,   32'h3FFF_0001, 0);
        run_op("minxmax",    16'h8000,   16'h7FFF,   32'hC000_8000, 0);
        run_op("m1xm1",      16'hFFFF,   16'hFFFF,   32'h0000_0001, 2);

        // Backpressure with in_valid pulsing during DONE.
        a = 16'd100;
        b = 16'hFFFD;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin
            tick();
            seen++;
        end
        chk("bp_latency", 32'(seen), 32'd8);
        for (int i = 0; i < 5; i++) begin
            a = 16'(i + 11);
            b = 16'(i + 3);
            in_valid = (i % 2 == 0);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_product", product, 32'hFFFF_FED4);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_drain_ready", 32'(in_ready), 32'd1);
        chk("bp_drain_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("bp_no_second_op", 32'(seen), 32'd0);

        // Reset during the 4th RUN cycle.
        a = 16'd7;
        b = 16'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_product", product, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_rst_no_pulse", 32'(seen), 32'd0);
        run_op("7xm9", 16'd7, 16'hFFF7, 32'hFFFF_FFC1, 0);

        // Randomized operands against a signed-multiply reference.
        for (int k = 0; k < 300; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ref_p = $signed(ra) * $signed(rb);
            run_op("rand", ra, rb, ref_p, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
